sema_req_cond: RTL
==================

SEMA_REQ_COND -- requirements
Module: sema_req_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 8, stable-input cycles required to accept a press or release (legal range 2..255).
REQ-002 The block SHALL have parameter LOCKOUT_CYCLES, default 16, cycles after an accepted ack during which new presses are rejected (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port btn_raw, input, 1, asynchronous pedestrian push-button level (1 = pressed).
REQ-006 The block SHALL have port ack_i, input, 1, acknowledge from the downstream semaphore controller.
REQ-007 The block SHALL have port req_o, output, 1, registered pending crossing request to the controller.
REQ-008 The block SHALL have port btn_level_o, output, 1, debounced button level.
REQ-009 The block SHALL have port lock_o, output, 1, high while lockout is active.
REQ-010 The block SHALL have port drop_cnt_o, output, 8, saturating count of rejected presses.

Function
REQ-011 The block SHALL pass btn_raw through a 2-flop synchronizer; s2 denotes the second flop output; no other logic SHALL sample btn_raw.
REQ-012 The block SHALL implement a debounce FSM with states IDLE, DEB_PRESS, HELD, DEB_REL and an 8-bit counter cnt.
REQ-013 In IDLE with s2=1, the FSM SHALL go to DEB_PRESS with cnt=0; with s2=0 it SHALL stay in IDLE.
REQ-014 In DEB_PRESS, s2=0 SHALL return to IDLE; s2=1 with cnt=DEBOUNCE_CYCLES-1 SHALL go to HELD and raise a one-cycle internal press event; otherwise cnt SHALL increment.
REQ-015 In HELD with s2=0, the FSM SHALL go to DEB_REL with cnt=0; with s2=1 it SHALL stay in HELD.
REQ-016 In DEB_REL, s2=1 SHALL return to HELD (no new press event); s2=0 with cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-017 btn_level_o SHALL be 1 exactly when the FSM is in HELD or DEB_REL.
REQ-018 A press event with req_o=0 and lock_o=0 SHALL set req_o on the same edge the FSM enters HELD: the 11th rising edge (DEBOUNCE_CYCLES+3) after a clean btn_raw rise.
REQ-019 A press event with req_o=1 or lock_o=1 SHALL leave req_o unchanged and increment drop_cnt_o, saturating at 255.
REQ-020 ack_i sampled high while req_o=1 SHALL clear req_o and load the lockout counter with LOCKOUT_CYCLES on that edge.
REQ-021 ack_i sampled high while req_o=0 SHALL be ignored (no state change).
REQ-022 lock_o SHALL be 1 while the lockout counter is nonzero; the counter SHALL decrement each cycle, giving exactly LOCKOUT_CYCLES cycles of lock_o=1.
REQ-023 A press event on the same edge as an accepted ack SHALL be rejected and counted as dropped; req_o SHALL go to 0.
REQ-024 req_o SHALL remain high indefinitely until acknowledged; there is no timeout.

Reset
REQ-025 Asserting nReset low SHALL, asynchronously, force both synchronizer flops to 0, FSM to IDLE, cnt=0, req_o=0, btn_level_o=0, lock_o=0, lockout counter=0, drop_cnt_o=0.
REQ-026 Reset asserted mid-debounce, mid-request or mid-lockout SHALL abandon that operation; no press event SHALL be generated from pre-reset history.
REQ-027 After nReset deasserts with btn_raw held high, the block SHALL treat it as a new press subject to full debounce.

Structure
REQ-028 The FSM state enum typedef and the counter width constant (8) SHALL live in the shared package sema_pkg.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module named sema_sync2; all other logic SHALL stay in sema_req_cond.

Verification
REQ-030 Clean press: btn_raw high 20 cycles, ack_i=0 -> req_o rises on the 11th edge, btn_level_o=1, drop_cnt_o=0.
REQ-031 Glitch: btn_raw high 5 cycles then low -> req_o, btn_level_o stay 0 throughout.
REQ-032 Bounce on release: HELD, btn_raw low 4 cycles, high 2, low 20 -> exactly one press event total and btn_level_o falls once.
REQ-033 Handshake plus lockout: req_o=1, ack_i pulse 1 cycle -> req_o=0 next edge; lock_o=1 for exactly 16 cycles; a press completed inside the lockout -> drop_cnt_o=1, req_o stays 0.
REQ-034 Saturation and coincidence: 300 presses with req_o held (no ack) -> drop_cnt_o=255; a press coinciding with ack -> req_o=0 and the drop is counted.
REQ-035 Reset mid-debounce: nReset low 3 cycles during DEB_PRESS with btn_raw high -> all outputs 0; after release req_o rises 11 edges after reset deassertion.

Source files
------------

// File: rtl/sema_pkg.sv
// Shared types and widths for the pedestrian request conditioner.
package sema_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_t;

endpackage

// File: rtl/sema_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
// Latency 2 cycles; no flow control.
module sema_sync2 (
  input  logic clk,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sema_req_cond.sv
// Debounces a pedestrian button and turns accepted presses into a held request with ack lockout.
// Request rises DEBOUNCE_CYCLES+3 edges after a clean press; presses during a pending request or lockout are counted as drops.
module sema_req_cond
  import sema_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             btn_raw,
  input  logic             ack_i,
  output logic             req_o,
  output logic             btn_level_o,
  output logic             lock_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             s2;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lock_cnt;
  logic             press_evt;
  logic             ack_acc;
  logic             drop;

  sema_sync2 u_sync (
    .clk    (clk),
    .nReset (nReset),
    .d      (btn_raw),
    .q      (s2)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_evt = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = DEB_PRESS;
          cnt_n   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s2) begin
          state_n = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n   = HELD;
          press_evt = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_n = DEB_REL;
          cnt_n   = '0;
        end
      end
      DEB_REL: begin
        // A bounce back high resumes the existing hold; it is not a new press.
        if (s2) begin
          state_n = HELD;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A press landing on the same edge as an accepted ack is treated as a drop.
  assign ack_acc = ack_i & req_o;
  assign drop    = press_evt & (req_o | lock_o | ack_acc);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      req_o      <= 1'b0;
      lock_cnt   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (ack_acc) begin
        req_o <= 1'b0;
      end else if (press_evt && !lock_o) begin
        req_o <= 1'b1;
      end

      if (ack_acc) begin
        lock_cnt <= LOCK_LD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - CNT_W'(1);
      end

      if (drop && drop_cnt_o != CNT_MAX) begin
        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      end
    end
  end

  assign lock_o      = (lock_cnt != '0);
  assign btn_level_o = (state == HELD) || (state == DEB_REL);

endmodule
